// File: rtl/alu_rs_pkg.sv
// Shared widths and op encodings for the ALU reservation station.
package alu_rs_pkg;

  localparam int DATA_W = 32;
  localparam int ROB_W  = 4;
  localparam int OP_W   = 6;
  localparam int RS_N   = 8;

  localparam logic [DATA_W-1:0] ZERO_DATA = '0;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 6'd0,
    OP_ADD  = 6'd1,
    OP_SUB  = 6'd2,
    OP_AND  = 6'd3,
    OP_OR   = 6'd4,
    OP_XOR  = 6'd5,
    OP_SLL  = 6'd6,
    OP_SRL  = 6'd7,
    OP_SLT  = 6'd8,
    OP_BEQ  = 6'd16,
    OP_BNE  = 6'd17,
    OP_JAL  = 6'd24,
    OP_AUIPC = 6'd25
  } alu_op_e;

endpackage

// File: rtl/alu_rs_if.sv
// Dispatch, CDB snoop and ALU issue bundle around the reservation station.
interface alu_rs_if
  import alu_rs_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int RW = ROB_W,
  parameter int OW = OP_W
) ();

  logic          in_ena;
  logic [OW-1:0] in_op;
  logic [RW-1:0] in_rob_tag;
  logic [DW-1:0] in_pc;
  logic [DW-1:0] in_imm;
  logic [DW-1:0] in_vj;
  logic [RW-1:0] in_qj;
  logic          in_rj;
  logic [DW-1:0] in_vk;
  logic [RW-1:0] in_qk;
  logic          in_rk;

  logic          cdb_alu_ena;
  logic [RW-1:0] cdb_alu_tag;
  logic [DW-1:0] cdb_alu_data;
  logic          cdb_lsb_ena;
  logic [RW-1:0] cdb_lsb_tag;
  logic [DW-1:0] cdb_lsb_data;

  logic          full;
  logic          alu_ena;
  logic [OW-1:0] alu_op;
  logic [RW-1:0] alu_rob_tag;
  logic [DW-1:0] alu_pc;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_imm;

  modport master (
    output in_ena, in_op, in_rob_tag, in_pc, in_imm,
    output in_vj, in_qj, in_rj, in_vk, in_qk, in_rk,
    output cdb_alu_ena, cdb_alu_tag, cdb_alu_data,
    output cdb_lsb_ena, cdb_lsb_tag, cdb_lsb_data,
    input  full, alu_ena, alu_op, alu_rob_tag,
    input  alu_pc, alu_a, alu_b, alu_imm
  );

  modport slave (
    input  in_ena, in_op, in_rob_tag, in_pc, in_imm,
    input  in_vj, in_qj, in_rj, in_vk, in_qk, in_rk,
    input  cdb_alu_ena, cdb_alu_tag, cdb_alu_data,
    input  cdb_lsb_ena, cdb_lsb_tag, cdb_lsb_data,
    output full, alu_ena, alu_op, alu_rob_tag,
    output alu_pc, alu_a, alu_b, alu_imm
  );

endinterface

// File: rtl/alu_rs_priority_encoder.sv
// Lowest-set-bit finder with a found flag.
module rs_priority_encoder #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 found_o
);

  localparam int IW = $clog2(N);

  // Scan high to low so the lowest set bit is written last.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers ops until operands arrive, issues one per cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE    = RS_N,
  parameter int DATA_WIDTH = DATA_W,
  parameter int ROB_WIDTH  = ROB_W,
  parameter int OP_WIDTH   = OP_W
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   rollback,
  alu_rs_if.slave bus
);

  localparam int IW = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]    busy_q, rj_q, rk_q, ready;
  logic [OP_WIDTH-1:0]   op_q  [RS_SIZE];
  logic [ROB_WIDTH-1:0]  tag_q [RS_SIZE];
  logic [DATA_WIDTH-1:0] pc_q  [RS_SIZE];
  logic [DATA_WIDTH-1:0] imm_q [RS_SIZE];
  logic [DATA_WIDTH-1:0] vj_q  [RS_SIZE];
  logic [DATA_WIDTH-1:0] vk_q  [RS_SIZE];
  logic [ROB_WIDTH-1:0]  qj_q  [RS_SIZE];
  logic [ROB_WIDTH-1:0]  qk_q  [RS_SIZE];

  logic                  alu_ena_q;
  logic [OP_WIDTH-1:0]   alu_op_q;
  logic [ROB_WIDTH-1:0]  alu_tag_q;
  logic [DATA_WIDTH-1:0] alu_pc_q, alu_a_q;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_imm_q;

  logic [IW-1:0]         free_idx, iss_idx;
  logic                  free_ok, iss_ok, disp;
  logic [DATA_WIDTH-1:0] vj_d, vk_d;
  logic                  rj_d, rk_d;

  assign ready    = busy_q & rj_q & rk_q;
  assign bus.full = &busy_q;
  assign disp     = bus.in_ena & free_ok & ~rollback;

  rs_priority_encoder #(.N(RS_SIZE)) u_free (
    .req_i   (~busy_q),
    .idx_o   (free_idx),
    .found_o (free_ok)
  );

  rs_priority_encoder #(.N(RS_SIZE)) u_issue (
    .req_i   (ready),
    .idx_o   (iss_idx),
    .found_o (iss_ok)
  );

  // Dispatch-time bypass; the ALU bus wins a double match.
  always_comb begin
    vj_d = bus.in_vj;
    rj_d = bus.in_rj;
    vk_d = bus.in_vk;
    rk_d = bus.in_rk;
    if (!bus.in_rj) begin
      if (bus.cdb_alu_ena && bus.cdb_alu_tag == bus.in_qj) begin
        vj_d = bus.cdb_alu_data;
        rj_d = 1'b1;
      end else if (bus.cdb_lsb_ena && bus.cdb_lsb_tag == bus.in_qj) begin
        vj_d = bus.cdb_lsb_data;
        rj_d = 1'b1;
      end
    end
    if (!bus.in_rk) begin
      if (bus.cdb_alu_ena && bus.cdb_alu_tag == bus.in_qk) begin
        vk_d = bus.cdb_alu_data;
        rk_d = 1'b1;
      end else if (bus.cdb_lsb_ena && bus.cdb_lsb_tag == bus.in_qk) begin
        vk_d = bus.cdb_lsb_data;
        rk_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      alu_ena_q <= 1'b0;
      alu_op_q  <= '0;
      alu_tag_q <= '0;
      alu_pc_q  <= ZERO_DATA;
      alu_a_q   <= ZERO_DATA;
      alu_b_q   <= ZERO_DATA;
      alu_imm_q <= ZERO_DATA;
    end else if (rollback) begin
      busy_q    <= '0;
      alu_ena_q <= 1'b0;
    end else begin
      alu_ena_q <= iss_ok;
      if (iss_ok) begin
        busy_q[iss_idx] <= 1'b0;
        alu_op_q  <= op_q[iss_idx];
        alu_tag_q <= tag_q[iss_idx];
        alu_pc_q  <= pc_q[iss_idx];
        alu_a_q   <= vj_q[iss_idx];
        alu_b_q   <= vk_q[iss_idx];
        alu_imm_q <= imm_q[iss_idx];
      end
      if (disp) busy_q[free_idx] <= 1'b1;
    end
  end

  // Payload is only meaningful while busy, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i] && !rj_q[i]) begin
        if (bus.cdb_alu_ena && bus.cdb_alu_tag == qj_q[i]) begin
          vj_q[i] <= bus.cdb_alu_data;
          rj_q[i] <= 1'b1;
        end else if (bus.cdb_lsb_ena && bus.cdb_lsb_tag == qj_q[i]) begin
          vj_q[i] <= bus.cdb_lsb_data;
          rj_q[i] <= 1'b1;
        end
      end
      if (busy_q[i] && !rk_q[i]) begin
        if (bus.cdb_alu_ena && bus.cdb_alu_tag == qk_q[i]) begin
          vk_q[i] <= bus.cdb_alu_data;
          rk_q[i] <= 1'b1;
        end else if (bus.cdb_lsb_ena && bus.cdb_lsb_tag == qk_q[i]) begin
          vk_q[i] <= bus.cdb_lsb_data;
          rk_q[i] <= 1'b1;
        end
      end
    end
    if (disp) begin
      op_q[free_idx]  <= bus.in_op;
      tag_q[free_idx] <= bus.in_rob_tag;
      pc_q[free_idx]  <= bus.in_pc;
      imm_q[free_idx] <= bus.in_imm;
      vj_q[free_idx]  <= vj_d;
      qj_q[free_idx]  <= bus.in_qj;
      rj_q[free_idx]  <= rj_d;
      vk_q[free_idx]  <= vk_d;
      qk_q[free_idx]  <= bus.in_qk;
      rk_q[free_idx]  <= rk_d;
    end
  end

  assign bus.alu_ena     = alu_ena_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_rob_tag = alu_tag_q;
  assign bus.alu_pc      = alu_pc_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_imm     = alu_imm_q;

endmodule

// File: tb/tb_alu_rs.sv
// Directed scoreboard bench for the ALU reservation station.
module tb_alu_rs;
  import alu_rs_pkg::*;

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] imm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rollback = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  exp_t sbq[$];

  alu_rs_if bus ();

  alu_rs dut (
    .clk      (clk),
    .rst      (rst),
    .rollback (rollback),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.alu_ena === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_issue", 64'(bus.alu_rob_tag), 64'hff);
      end else begin
        e = sbq.pop_front();
        chk("issue_op", 64'(bus.alu_op), 64'(e.op));
        chk("issue_tag", 64'(bus.alu_rob_tag), 64'(e.tag));
        chk("issue_a", 64'(bus.alu_a), 64'(e.a));
        chk("issue_b", 64'(bus.alu_b), 64'(e.b));
        chk("issue_pc", 64'(bus.alu_pc), 64'(e.pc));
        chk("issue_imm", 64'(bus.alu_imm), 64'(e.imm));
      end
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [3:0] tag,
                       input logic [31:0] vj, input logic [3:0] qj,
                       input logic rj, input logic [31:0] vk,
                       input logic [3:0] qk, input logic rk);
    bus.in_ena     = 1'b1;
    bus.in_op      = op;
    bus.in_rob_tag = tag;
    bus.in_pc      = 32'h1000 + 32'(tag) * 4;
    bus.in_imm     = 32'h100 + 32'(tag);
    bus.in_vj      = vj;
    bus.in_qj      = qj;
    bus.in_rj      = rj;
    bus.in_vk      = vk;
    bus.in_qk      = qk;
    bus.in_rk      = rk;
  endtask

  task automatic expect_issue(input logic [5:0] op, input logic [3:0] tag,
                              input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.op  = op;
    e.tag = tag;
    e.a   = a;
    e.b   = b;
    e.pc  = 32'h1000 + 32'(tag) * 4;
    e.imm = 32'h100 + 32'(tag);
    sbq.push_back(e);
  endtask

  task automatic cdb_off();
    bus.cdb_alu_ena = 1'b0;
    bus.cdb_lsb_ena = 1'b0;
  endtask

  initial begin
    bus.in_ena = 1'b0;
    bus.in_op = '0;
    bus.in_rob_tag = '0;
    bus.in_pc = '0;
    bus.in_imm = '0;
    bus.in_vj = '0;
    bus.in_qj = '0;
    bus.in_rj = 1'b0;
    bus.in_vk = '0;
    bus.in_qk = '0;
    bus.in_rk = 1'b0;
    bus.cdb_alu_ena = 1'b0;
    bus.cdb_alu_tag = '0;
    bus.cdb_alu_data = '0;
    bus.cdb_lsb_ena = 1'b0;
    bus.cdb_lsb_tag = '0;
    bus.cdb_lsb_data = '0;

    #7;
    chk("rst_ena", 64'(bus.alu_ena), 64'd0);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_a", 64'(bus.alu_a), 64'd0);
    chk("rst_tag", 64'(bus.alu_rob_tag), 64'd0);
    #5 rst = 1'b0;

    // Both operands ready: issue one edge after dispatch.
    drive(OP_ADD, 4'd3, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 1'b1);
    expect_issue(OP_ADD, 4'd3, 32'd5, 32'd7);
    step();
    bus.in_ena = 1'b0;
    chk("t1_not_yet", 64'(bus.alu_ena), 64'd0);
    step();
    chk("t1_issue", 64'(bus.alu_ena), 64'd1);
    step();
    chk("t1_idle", 64'(bus.alu_ena), 64'd0);

    // Operand A waits on a load result.
    drive(OP_SUB, 4'd6, 32'd0, 4'd2, 1'b0, 32'd1, 4'd0, 1'b1);
    step();
    bus.in_ena = 1'b0;
    step();
    chk("t2_wait", 64'(bus.alu_ena), 64'd0);
    bus.cdb_lsb_ena = 1'b1;
    bus.cdb_lsb_tag = 4'd2;
    bus.cdb_lsb_data = 32'h1234;
    expect_issue(OP_SUB, 4'd6, 32'h1234, 32'd1);
    step();
    cdb_off();
    chk("t2_wake_edge", 64'(bus.alu_ena), 64'd0);
    step();
    chk("t2_issue", 64'(bus.alu_ena), 64'd1);

    // Same-cycle bypass on operand B.
    drive(OP_AND, 4'd7, 32'd3, 4'd0, 1'b1, 32'd0, 4'd4, 1'b0);
    bus.cdb_alu_ena = 1'b1;
    bus.cdb_alu_tag = 4'd4;
    bus.cdb_alu_data = 32'd9;
    expect_issue(OP_AND, 4'd7, 32'd3, 32'd9);
    step();
    bus.in_ena = 1'b0;
    cdb_off();
    step();
    chk("t3_issue", 64'(bus.alu_ena), 64'd1);
    step();

    // Fill all entries waiting on tag 1.
    for (int i = 0; i < 8; i++) begin
      drive(OP_OR, 4'(i), 32'd0, 4'd1, 1'b0, 32'(i + 40), 4'd0, 1'b1);
      expect_issue(OP_OR, 4'(i), 32'h55, 32'(i + 40));
      step();
    end
    bus.in_ena = 1'b0;
    chk("t4_full", 64'(bus.full), 64'd1);
    drive(OP_XOR, 4'd15, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 1'b1);
    step();
    bus.in_ena = 1'b0;
    chk("t4_drop_full", 64'(bus.full), 64'd1);
    chk("t4_drop_ena", 64'(bus.alu_ena), 64'd0);
    bus.cdb_alu_ena = 1'b1;
    bus.cdb_alu_tag = 4'd1;
    bus.cdb_alu_data = 32'h55;
    step();
    cdb_off();
    chk("t4_wake_full", 64'(bus.full), 64'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t4_drain_ena", 64'(bus.alu_ena), 64'd1);
      if (i == 0) chk("t4_full_drop", 64'(bus.full), 64'd0);
    end
    step();
    chk("t4_no_ninth", 64'(bus.alu_ena), 64'd0);

    // Both CDBs carry the same tag: ALU data wins.
    drive(OP_SLT, 4'd9, 32'd0, 4'd5, 1'b0, 32'd0, 4'd0, 1'b1);
    step();
    bus.in_ena = 1'b0;
    bus.cdb_alu_ena = 1'b1;
    bus.cdb_alu_tag = 4'd5;
    bus.cdb_alu_data = 32'd10;
    bus.cdb_lsb_ena = 1'b1;
    bus.cdb_lsb_tag = 4'd5;
    bus.cdb_lsb_data = 32'd20;
    expect_issue(OP_SLT, 4'd9, 32'd10, 32'd0);
    step();
    cdb_off();
    step();
    chk("t5_issue", 64'(bus.alu_ena), 64'd1);
    step();

    // Rollback with three busy entries, one of them ready.
    drive(OP_BEQ, 4'd10, 32'd0, 4'd12, 1'b0, 32'd0, 4'd0, 1'b1);
    step();
    drive(OP_BNE, 4'd11, 32'd0, 4'd12, 1'b0, 32'd0, 4'd0, 1'b1);
    step();
    drive(OP_ADD, 4'd13, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 1'b1);
    step();
    bus.in_ena = 1'b0;
    chk("t6_pre_ena", 64'(bus.alu_ena), 64'd0);
    rollback = 1'b1;
    step();
    rollback = 1'b0;
    chk("t6_rb_ena", 64'(bus.alu_ena), 64'd0);
    chk("t6_rb_full", 64'(bus.full), 64'd0);
    bus.cdb_alu_ena = 1'b1;
    bus.cdb_alu_tag = 4'd12;
    bus.cdb_alu_data = 32'h77;
    step();
    cdb_off();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_issue", 64'(bus.alu_ena), 64'd0);
    end
    chk("t6_sb_empty", 64'(sbq.size()), 64'd0);

    // Asynchronous reset with a ready op pending.
    drive(OP_ADD, 4'd14, 32'd2, 4'd0, 1'b1, 32'd3, 4'd0, 1'b1);
    step();
    bus.in_ena = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_ena", 64'(bus.alu_ena), 64'd0);
    chk("t7_rst_a", 64'(bus.alu_a), 64'd0);
    chk("t7_rst_full", 64'(bus.full), 64'd0);
    #2 rst = 1'b0;
    step();
    chk("t7_no_issue", 64'(bus.alu_ena), 64'd0);
    step();
    chk("t7_still_idle", 64'(bus.alu_ena), 64'd0);
    chk("end_sb_empty", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station feeding the integer ALU in the out-of-order core. It sits between the dispatcher and the ALU execute port.
- Buffers decoded ALU/branch/address ops until both operands are available, snooping both common data buses (ALU result, load result) for pending tags.
- Issues at most one ready op per cycle to the ALU on a registered interface.

Parameters:
- RS_SIZE, 8: number of entries; must be a power of two, at least 2.
- DATA_WIDTH, 32: operand, pc and imm width.
- ROB_WIDTH, 4: ROB tag width.
- OP_WIDTH, 6: internal operation code width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rollback  in  1  misprediction flush; synchronous clear.
- in_ena  in  1  dispatch valid.
- in_op  in  OP_WIDTH  operation.
- in_rob_tag  in  ROB_WIDTH  destination ROB tag.
- in_pc  in  DATA_WIDTH  instruction pc.
- in_imm  in  DATA_WIDTH  immediate.
- in_vj  in  DATA_WIDTH  operand A value.
- in_qj  in  ROB_WIDTH  operand A producer tag.
- in_rj  in  1  operand A ready; when 1, in_qj is ignored.
- in_vk, in_qk, in_rk: same as above for operand B.
- cdb_alu_ena  in  1  ALU result broadcast valid.
- cdb_alu_tag  in  ROB_WIDTH  ALU result tag.
- cdb_alu_data  in  DATA_WIDTH  ALU result data.
- cdb_lsb_ena, cdb_lsb_tag, cdb_lsb_data: same as above for load results.
- full  out  1  no free entry; dispatcher must hold.
- alu_ena  out  1  issue valid to ALU.
- alu_op  out  OP_WIDTH  issued op.
- alu_rob_tag  out  ROB_WIDTH  issued tag.
- alu_pc  out  DATA_WIDTH  issued pc.
- alu_a, alu_b, alu_imm  out  DATA_WIDTH  issued operands.

Behaviour:
- Entry state: busy, op, tag, pc, imm, vj/qj/rj, vk/qk/rk.
- Reset (async): all busy=0; alu_ena=0; alu_op, alu_rob_tag, alu_pc, alu_a, alu_b, alu_imm = 0; full=0.
- full: combinational, equals AND of all busy bits. It reflects only the current busy state; a same-cycle issue does not free space for a same-cycle dispatch.
- Dispatch: on a clock edge with in_ena=1, full=0 and rollback=0, write the lowest-index non-busy entry and set busy=1. in_ena while full is ignored; no state change.
- Dispatch-time bypass: if an incoming operand has r=0 and its q matches a CDB broadcast in the same cycle, store the CDB data with r=1.
- Snoop: every edge, each busy entry with rj=0 and qj==cdb tag (ena=1) captures the data and sets rj=1; likewise for k. Both CDBs are checked. If both match the same tag, cdb_alu wins.
- Ready: busy & rj & rk, evaluated from registered state only. A wakeup at edge t makes the entry eligible for selection at edge t+1.
- Issue selection: lowest-index ready entry. At the edge:
  - alu_* outputs load that entry's fields; alu_ena=1.
  - The entry's busy is cleared.
  - If no entry is ready, alu_ena=0 and the other alu_* outputs hold their values.
- Latency: an op dispatched with both operands ready at edge t appears with alu_ena=1 after edge t+1. Minimum residency is one cycle; there is no dispatch-to-issue combinational path.
- Throughput: one dispatch and one issue per cycle, allowed simultaneously, including on different entries.
- Rollback: at the edge, all busy=0 and alu_ena=0. Same-cycle dispatch, snoop and issue are discarded. Takes priority over everything except rst.
- Reset mid-operation: all contents lost immediately; no partial issue.
- Tags: equality compare over full ROB_WIDTH. No tag value is reserved; readiness is carried only by the r bits.

Decomposition:
- constant.v holds:
  - the width macros (DATA_WIDTH, ROB_WIDTH, OPERATION_BUS);
  - TRUE/FALSE and ZERO_DATA;
  - the op encodings.
- Parameter defaults derive from these macros.
- One natural sub-module: rs_priority_encoder, a parameterised lowest-set-bit finder with a found flag. It is instantiated twice, once for the free slot (on ~busy) and once for the issue slot (on the ready vector).

Test Plan:
- Reset then dispatch ADD with rj=rk=1, vj=5, vk=7, tag=3 → next edge: alu_ena=1, alu_a=5, alu_b=7, alu_rob_tag=3, op=ADD; one cycle later alu_ena=0.
- Dispatch op with rj=0, qj=2 → no issue. cdb_lsb broadcasts tag 2, data 0x1234 → entry captures the data; alu_ena=1 one edge later with alu_a=0x1234.
- Same-cycle bypass: dispatch with qk=4 while cdb_alu_ena=1, tag=4, data=9 → issues next edge with alu_b=9.
- Fill 8 entries, all waiting on tag 1 → full=1 and a ninth in_ena is dropped. Broadcast tag 1 → entries issue in index order 0..7 on consecutive edges, and full drops after the first issue edge.
- Both CDBs broadcast tag 5 with data 10 (alu) and 20 (lsb) → waiting operand captures 10.
- Rollback with 3 busy entries, one of them ready → next edge: alu_ena=0, full=0, and no later issue of the flushed ops.
